// File: rtl/proj_point_pkg.sv
// Shared RGB-D visual-odometry configuration: fixed-point widths and frame geometry.
package RgbdVoConfigPk;

  localparam int CLOUD_BW  = 42;
  localparam int MUL       = 24;
  localparam int CALIB_BW  = 35;
  localparam int IMG_W     = 640;
  localparam int IMG_H     = 480;
  localparam int H_SIZE_BW = $clog2(IMG_W);
  localparam int V_SIZE_BW = $clog2(IMG_H);

endpackage

// File: rtl/proj_div_pipe.sv
// Pipelined unsigned restoring divider: one quotient bit per stage, MSB first, with an
// overflow (saturation) check at the head and side data carried alongside each point.
module proj_div_pipe #(
  parameter int N_BW    = 77,
  parameter int D_BW    = 64,
  parameter int Q_BW    = 12,
  parameter int SIDE_BW = 11
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [N_BW-1:0]    i_num,
  input  logic [D_BW-1:0]    i_den,
  input  logic               i_sat,
  input  logic [SIDE_BW-1:0] i_side,
  output logic               o_valid,
  output logic [Q_BW:0]      o_quo,
  output logic               o_sat,
  output logic [SIDE_BW-1:0] o_side
);

  localparam int QW = Q_BW + 1;
  localparam int CW = ((N_BW > D_BW + QW) ? N_BW : D_BW + QW) + 1;

  for (genvar s = 0; s < QW; s++) begin : g_stage
    localparam int K = Q_BW - s;

    logic [N_BW-1:0]    rem_in;
    logic [D_BW-1:0]    den_in;
    logic [QW-1:0]      quo_in;
    logic               sat_in;
    logic [SIDE_BW-1:0] side_in;
    logic               vld_in;
    logic [CW-1:0]      trial;
    logic               fits;

    logic [N_BW-1:0]    rem_p;
    logic [D_BW-1:0]    den_p;
    logic [QW-1:0]      quo_p;
    logic               sat_p;
    logic [SIDE_BW-1:0] side_p;
    logic               vld_p;

    if (s == 0) begin : g_head
      // Any quotient needing more than QW bits cannot be represented: flag it up front.
      assign sat_in  = i_sat | (CW'(i_num) >= (CW'(i_den) << QW));
      assign rem_in  = i_num;
      assign den_in  = i_den;
      assign quo_in  = '0;
      assign side_in = i_side;
      assign vld_in  = i_valid;
    end else begin : g_body
      assign sat_in  = g_stage[s-1].sat_p;
      assign rem_in  = g_stage[s-1].rem_p;
      assign den_in  = g_stage[s-1].den_p;
      assign quo_in  = g_stage[s-1].quo_p;
      assign side_in = g_stage[s-1].side_p;
      assign vld_in  = g_stage[s-1].vld_p;
    end

    assign trial = CW'(den_in) << K;
    assign fits  = CW'(rem_in) >= trial;

    // Divider stage s boundary
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) vld_p <= 1'b0;
      else       vld_p <= vld_in;
    end

    always_ff @(posedge i_clk) begin
      rem_p  <= fits ? N_BW'(CW'(rem_in) - trial) : rem_in;
      quo_p  <= quo_in | (QW'(fits) << K);
      den_p  <= den_in;
      sat_p  <= sat_in;
      side_p <= side_in;
    end
  end

  assign o_valid = g_stage[QW-1].vld_p;
  assign o_quo   = g_stage[QW-1].quo_p;
  assign o_sat   = g_stage[QW-1].sat_p;
  assign o_side  = g_stage[QW-1].side_p;

endmodule

// File: rtl/proj_point.sv
// Pinhole projection of transformed cloud points to pixel indices with in-frame flag.
// Stage 0 multiplies by focal length, the dividers form f*p/z, the last stage rounds and offsets.
module proj_point #(
  parameter int  CLOUD_BW = RgbdVoConfigPk::CLOUD_BW,
  parameter int  FRAC_BW  = RgbdVoConfigPk::MUL,
  parameter int  CALIB_BW = RgbdVoConfigPk::CALIB_BW,
  parameter int  Q_BW     = 12,
  parameter int  IMG_W    = RgbdVoConfigPk::IMG_W,
  parameter int  IMG_H    = RgbdVoConfigPk::IMG_H,
  localparam int H_BW     = $clog2(IMG_W),
  localparam int V_BW     = $clog2(IMG_H)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  input  logic signed [CLOUD_BW-1:0] i_cloud_x,
  input  logic signed [CLOUD_BW-1:0] i_cloud_y,
  input  logic signed [CLOUD_BW-1:0] i_cloud_z,
  input  logic [CALIB_BW-1:0]        i_fx,
  input  logic [CALIB_BW-1:0]        i_fy,
  input  logic [H_BW-1:0]            i_cx,
  input  logic [V_BW-1:0]            i_cy,
  output logic                       o_valid,
  output logic [H_BW-1:0]            o_idx_x,
  output logic [V_BW-1:0]            o_idx_y,
  output logic                       o_in_frame
);

  localparam int PROD_BW = CLOUD_BW + CALIB_BW;
  // Divisor is z pre-scaled so the quotient carries one extra (half-pixel) bit.
  localparam int DEN_BW  = (CLOUD_BW - 1) + (FRAC_BW - 1);
  localparam int P_BW    = ((H_BW > V_BW) ? H_BW : V_BW) + Q_BW + 2;

  function automatic logic [CLOUD_BW-1:0] abs_mag(input logic signed [CLOUD_BW-1:0] a);
    return a[CLOUD_BW-1] ? (~a + 1'b1) : a;
  endfunction

  function automatic logic [Q_BW:0] round_mag(input logic [Q_BW:0] q);
    logic [Q_BW+1:0] t;
    t = {1'b0, q} + 1'b1;
    return t[Q_BW+1:1];
  endfunction

  function automatic logic signed [P_BW-1:0] offset(input logic [P_BW-1:0] c,
                                                     input logic neg, input logic [Q_BW:0] mag);
    logic signed [P_BW-1:0] m;
    m = signed'(P_BW'(mag));
    return signed'(c) + (neg ? -m : m);
  endfunction

  function automatic logic in_bounds(input logic signed [P_BW-1:0] p, input int lim);
    return !p[P_BW-1] && (p < signed'(P_BW'(lim)));
  endfunction

  logic [PROD_BW-1:0]  nx_p0, ny_p0;
  logic                neg_x_p0, neg_y_p0, zpos_p0, vld_p0;
  logic [CLOUD_BW-2:0] dz_p0;
  logic [H_BW-1:0]     cx_p0;
  logic [V_BW-1:0]     cy_p0;

  // Stage 0: focal multiply on magnitudes, capture signs, depth and principal point
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) vld_p0 <= 1'b0;
    else       vld_p0 <= i_valid;
  end

  always_ff @(posedge i_clk) begin
    nx_p0    <= PROD_BW'(abs_mag(i_cloud_x)) * PROD_BW'(i_fx);
    ny_p0    <= PROD_BW'(abs_mag(i_cloud_y)) * PROD_BW'(i_fy);
    neg_x_p0 <= i_cloud_x[CLOUD_BW-1];
    neg_y_p0 <= i_cloud_y[CLOUD_BW-1];
    zpos_p0  <= !i_cloud_z[CLOUD_BW-1] && (|i_cloud_z[CLOUD_BW-2:0]);
    dz_p0    <= i_cloud_z[CLOUD_BW-2:0];
    cx_p0    <= i_cx;
    cy_p0    <= i_cy;
  end

  logic [DEN_BW-1:0] den_p0;
  assign den_p0 = {dz_p0, {(FRAC_BW-1){1'b0}}};

  logic            vld_x, vld_y, sat_x, sat_y;
  logic [Q_BW:0]   quo_x, quo_y;
  logic [H_BW:0]   side_x;
  logic [V_BW:0]   side_y;

  proj_div_pipe #(.N_BW(PROD_BW), .D_BW(DEN_BW), .Q_BW(Q_BW), .SIDE_BW(H_BW + 1)) u_div_x (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(vld_p0), .i_num(nx_p0), .i_den(den_p0),
    .i_sat(!zpos_p0), .i_side({neg_x_p0, cx_p0}),
    .o_valid(vld_x), .o_quo(quo_x), .o_sat(sat_x), .o_side(side_x)
  );

  proj_div_pipe #(.N_BW(PROD_BW), .D_BW(DEN_BW), .Q_BW(Q_BW), .SIDE_BW(V_BW + 1)) u_div_y (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(vld_p0), .i_num(ny_p0), .i_den(den_p0),
    .i_sat(!zpos_p0), .i_side({neg_y_p0, cy_p0}),
    .o_valid(vld_y), .o_quo(quo_y), .o_sat(sat_y), .o_side(side_y)
  );

  logic signed [P_BW-1:0] u_pf, v_pf;
  logic                   vld_pf, inf_pf;

  assign u_pf   = offset(P_BW'(side_x[H_BW-1:0]), side_x[H_BW], round_mag(quo_x));
  assign v_pf   = offset(P_BW'(side_y[V_BW-1:0]), side_y[V_BW], round_mag(quo_y));
  assign vld_pf = vld_x & vld_y;
  assign inf_pf = vld_pf && !sat_x && !sat_y && in_bounds(u_pf, IMG_W) && in_bounds(v_pf, IMG_H);

  // Final stage: registered outputs, indices forced to zero when off-frame or idle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid    <= 1'b0;
      o_idx_x    <= '0;
      o_idx_y    <= '0;
      o_in_frame <= 1'b0;
    end else begin
      o_valid    <= vld_pf;
      o_idx_x    <= inf_pf ? H_BW'(u_pf) : '0;
      o_idx_y    <= inf_pf ? V_BW'(v_pf) : '0;
      o_in_frame <= inf_pf;
    end
  end

endmodule

// File: tb/tb_proj_point.sv
// Bench for proj_point: directed spec points, random stream against a real-valued model,
// and a mid-stream reset; every output cycle is checked for exact latency and order.
module tb_proj_point;
  import RgbdVoConfigPk::*;

  localparam int  XB   = CLOUD_BW;
  localparam int  HB   = H_SIZE_BW;
  localparam int  VB   = V_SIZE_BW;
  localparam int  LAT  = 15;
  localparam real ONE  = 16777216.0;
  localparam real QLIM = 4096.0;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_valid;
  logic signed [XB-1:0] i_cloud_x, i_cloud_y, i_cloud_z;
  logic [CALIB_BW-1:0]  i_fx, i_fy;
  logic [HB-1:0]        i_cx;
  logic [VB-1:0]        i_cy;
  logic                 o_valid;
  logic [HB-1:0]        o_idx_x;
  logic [VB-1:0]        o_idx_y;
  logic                 o_in_frame;

  always #5 clk = ~clk;

  proj_point dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid),
    .i_cloud_x(i_cloud_x), .i_cloud_y(i_cloud_y), .i_cloud_z(i_cloud_z),
    .i_fx(i_fx), .i_fy(i_fy), .i_cx(i_cx), .i_cy(i_cy),
    .o_valid(o_valid), .o_idx_x(o_idx_x), .o_idx_y(o_idx_y), .o_in_frame(o_in_frame)
  );

  typedef struct {
    int due;
    int ix;
    int iy;
    int inf;
  } exp_t;

  exp_t exp_arr [256];
  int   wr = 0;
  int   rd = 0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint q24(input real r);
    return longint'(r * ONE);
  endfunction

  // Reference: real-valued pinhole projection, rounding half away from zero.
  function automatic exp_t model(input longint xq, yq, zq, fxq, fyq, input int cx, cy, due);
    exp_t e;
    real  ax, ay;
    int   mx, my, u, v;
    e.due = due; e.ix = 0; e.iy = 0; e.inf = 0;
    if (zq <= 0) return e;
    ax = real'(fxq) * real'(xq < 0 ? -xq : xq) / (real'(zq) * ONE);
    ay = real'(fyq) * real'(yq < 0 ? -yq : yq) / (real'(zq) * ONE);
    if (ax >= QLIM || ay >= QLIM) return e;
    mx = int'($floor(ax + 0.5));
    my = int'($floor(ay + 0.5));
    u = cx + (xq < 0 ? -mx : mx);
    v = cy + (yq < 0 ? -my : my);
    if (u >= 0 && u < IMG_W && v >= 0 && v < IMG_H) begin
      e.ix = u; e.iy = v; e.inf = 1;
    end
    return e;
  endfunction

  task automatic drive(input longint xq, yq, zq, fxq, fyq, input int cx, cy);
    i_valid   = 1'b1;
    i_cloud_x = XB'(xq);
    i_cloud_y = XB'(yq);
    i_cloud_z = XB'(zq);
    i_fx      = CALIB_BW'(fxq);
    i_fy      = CALIB_BW'(fyq);
    i_cx      = HB'(cx);
    i_cy      = VB'(cy);
  endtask

  task automatic send(input longint xq, yq, zq, fxq, fyq, input int cx, cy);
    drive(xq, yq, zq, fxq, fyq, cx, cy);
    exp_arr[wr] = model(xq, yq, zq, fxq, fyq, cx, cy, cyc + LAT);
    wr++;
    @(posedge clk); #1;
  endtask

  // Directed point with hand-derived expected outputs (fx=fy=525, cx=320, cy=240).
  task automatic send_k(input real x, y, z, input int kx, ky, kinf);
    longint f;
    f = longint'(525) <<< 24;
    drive(q24(x), q24(y), q24(z), f, f, 320, 240);
    exp_arr[wr].due = cyc + LAT;
    exp_arr[wr].ix  = kx;
    exp_arr[wr].iy  = ky;
    exp_arr[wr].inf = kinf;
    wr++;
    @(posedge clk); #1;
  endtask

  task automatic send_rand();
    longint xq, yq, zq, fxq, fyq;
    xq = longint'($urandom_range(0, 1 << 26)) - (longint'(1) <<< 25);
    yq = longint'($urandom_range(0, 50331648)) - 25165824;
    if ($urandom_range(0, 19) == 0) zq = -longint'($urandom_range(0, 1 << 24));
    else                            zq = longint'($urandom_range(5033165, 67108864));
    fxq = longint'($urandom_range(400 * 256, 700 * 256)) <<< 16;
    fyq = longint'($urandom_range(400 * 256, 700 * 256)) <<< 16;
    send(xq, yq, zq, fxq, fyq, int'($urandom_range(280, 360)), int'($urandom_range(200, 280)));
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_chk++;
    assert (obs === req) n_pass++;
    else $error("FAIL %s obs=%0d req=%0d (cycle %0d)", tag, obs, req, cyc);
  endtask

  // Output monitor: every cycle either the next expected point is due or outputs must be idle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) rd = wr;
      if (rd != wr && exp_arr[rd].due == cyc) begin
        chk("valid",    32'(o_valid),    32'd1);
        chk("idx_x",    32'(o_idx_x),    32'(exp_arr[rd].ix));
        chk("idx_y",    32'(o_idx_y),    32'(exp_arr[rd].iy));
        chk("in_frame", 32'(o_in_frame), 32'(exp_arr[rd].inf));
        rd++;
      end else begin
        chk("idle_outputs", {12'd0, o_valid, o_in_frame, o_idx_y, o_idx_x}, 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    i_valid = 1'b0;
    i_cloud_x = '0; i_cloud_y = '0; i_cloud_z = '0;
    i_fx = '0; i_fy = '0; i_cx = '0; i_cy = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    send_k( 0.1,  0.2, 1.0,   373, 345, 1);
    idle(LAT + 2);
    send_k(-0.1, -0.2, 1.0,   267, 135, 1);
    send_k( 0.1,  0.1, 0.0,   0,   0,   0);
    send_k( 0.1,  0.1, -1.0,  0,   0,   0);
    send_k(10.0,  0.0, 0.001, 0,   0,   0);
    send_k( 0.7,  0.0, 1.0,   0,   0,   0);
    send_k( 0.0,  0.0, 2.0,   320, 240, 1);
    idle(LAT + 5);

    repeat (100) send_rand();
    idle(LAT + 5);

    repeat (10) send_rand();
    i_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(LAT + 5);
    repeat (10) send_rand();
    idle(LAT + 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
